// File: rtl/ahb_lsu_manager_if.sv
// Core-side request/response handshake plus the AHB-Lite manager bus for the LSU.
// The master modport is the manager's view; slave is the core plus subordinate side.
interface ahb_lsu_manager_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  HSEL_MEM;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  resp_read;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
        input  rsp_ready, HRDATA, HREADY, HRESP,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output HSEL_MEM, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HWDATA, resp_read
    );

    modport slave (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
        output rsp_ready, HRDATA, HREADY, HRESP,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HSEL_MEM, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HWDATA, resp_read
    );
endinterface

// File: rtl/ahb_lsu_manager.sv
// AHB-Lite manager for the LSU: one single NONSEQ transfer at a time, with load
// lane extraction/extension, alignment checking and an optional data-phase timeout.
module ahb_lsu_manager #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic               HCLK,
    input logic               HRESET,
    ahb_lsu_manager_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [CNT_W-1:0]      r_wait_cnt;

    logic                  w_misaligned;
    logic                  w_timeout;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_wdata_rep;

    always_comb begin
        w_misaligned = 1'b0;
        case (bus.req_size)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = bus.req_addr[0];
            2'd2:    w_misaligned = |bus.req_addr[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    // The counter holds the number of stalled cycles already seen, so the abort
    // fires on the stalled cycle that brings the total to TIMEOUT.
    generate
        if (TIMEOUT != 0) begin : g_timeout
            assign w_timeout = !bus.HREADY && (r_wait_cnt == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        w_byte = bus.HRDATA[{r_addr[1:0], 3'b000} +: 8];
        w_half = bus.HRDATA[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'd0:    w_load_data = {{(DATA_WIDTH-8){!r_unsigned && w_byte[7]}}, w_byte};
            2'd1:    w_load_data = {{(DATA_WIDTH-16){!r_unsigned && w_half[15]}}, w_half};
            default: w_load_data = bus.HRDATA;
        endcase
    end

    always_comb begin
        case (r_size)
            2'd0:    w_wdata_rep = {(DATA_WIDTH/8){r_wdata[7:0]}};
            2'd1:    w_wdata_rep = {(DATA_WIDTH/16){r_wdata[15:0]}};
            default: w_wdata_rep = r_wdata;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.req_valid) w_state_next = w_misaligned ? S_RESP : S_ADDR;
            S_ADDR: if (bus.HREADY) w_state_next = S_DATA;
            S_DATA: if (bus.HRESP || bus.HREADY || w_timeout) w_state_next = S_RESP;
            S_RESP: if (bus.rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request capture and response formation; an error response always carries zero data.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr     <= bus.req_addr;
                        r_we       <= bus.req_we;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_wdata    <= bus.req_wdata;
                        r_rdata    <= '0;
                        r_err      <= w_misaligned;
                    end
                end
                S_ADDR: begin
                    if (bus.HREADY) r_wait_cnt <= '0;
                end
                S_DATA: begin
                    if (bus.HRESP) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else if (bus.HREADY) begin
                        r_err   <= 1'b0;
                        r_rdata <= r_we ? '0 : w_load_data;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.req_ready = (r_state == S_IDLE);
        bus.rsp_valid = (r_state == S_RESP);
        bus.rsp_rdata = (r_state == S_RESP) ? r_rdata : '0;
        bus.rsp_err   = (r_state == S_RESP) && r_err;
        bus.HSEL_MEM  = (r_state == S_ADDR);
        bus.HTRANS    = (r_state == S_ADDR) ? 2'b10 : 2'b00;
        bus.HADDR     = (r_state == S_ADDR) ? r_addr : '0;
        bus.HWRITE    = (r_state == S_ADDR) && r_we;
        bus.HSIZE     = (r_state == S_ADDR) ? {1'b0, r_size} : 3'b000;
        bus.resp_read = (r_state == S_ADDR) && !r_we;
        bus.HWDATA    = (r_state == S_DATA) ? w_wdata_rep : '0;
        bus.HBURST    = 3'b000;
        bus.HPROT     = 4'b0011;
        bus.HMASTLOCK = 1'b0;
    end
endmodule

// File: tb/tb_ahb_lsu_manager.sv
// Randomized and directed bench for ahb_lsu_manager: the bench plays core and
// subordinate, and predicts every response from the load/store rules directly.
module tb_ahb_lsu_manager;
    logic HCLK;
    logic HRESET;
    int   n_checks;
    int   n_errors;
    int   n_txn;

    ahb_lsu_manager_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) b ();
    ahb_lsu_manager_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) b2 ();

    ahb_lsu_manager #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT(255)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(b)
    );
    ahb_lsu_manager #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT(4)) dut_to (
        .HCLK(HCLK), .HRESET(HRESET), .bus(b2)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: the loaded value is the addressed byte/half of HRDATA, extended.
    function automatic logic [31:0] model_load(input logic [11:0] addr, input logic [1:0] size,
                                               input logic uns, input logic [31:0] hrdata);
        int unsigned v;
        if (size == 2'd0) begin
            v = (hrdata >> (8 * int'(addr[1:0]))) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = (hrdata >> (16 * int'(addr[1]))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = hrdata;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (size == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    // Called just after a rising edge with the manager idle; returns likewise.
    task automatic run_txn(input logic [11:0] addr, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata, input logic [31:0] hrdata,
                           input int aw, input int dw, input logic berr, input int rdly);
        logic        bad;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        int          exp_lat;
        int          lat;
        int          guard;
        bad     = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
        exp_err = bad || berr;
        exp_rd  = (exp_err || we) ? 32'h0 : model_load(addr, size, uns, hrdata);
        exp_wd  = model_wdata(size, wdata);
        exp_lat = bad ? 1 : 3 + aw + dw;

        b.req_valid    = 1'b1;
        b.req_addr     = addr;
        b.req_we       = we;
        b.req_size     = size;
        b.req_unsigned = uns;
        b.req_wdata    = wdata;
        b.HREADY       = 1'b1;
        b.HRESP        = 1'b0;
        @(negedge HCLK);
        chk("req_ready_idle", 32'(b.req_ready), 32'd1);
        @(posedge HCLK); #1;
        lat = 1;
        // request inputs become junk; the manager must ignore them until idle
        b.req_valid    = 1'($urandom);
        b.req_addr     = 12'($urandom);
        b.req_we       = 1'($urandom);
        b.req_size     = 2'($urandom);
        b.req_unsigned = 1'($urandom);
        b.req_wdata    = $urandom;

        if (!bad) begin
            for (int k = 0; k <= aw; k++) begin
                b.HREADY = (k == aw);
                b.HRDATA = $urandom;
                @(negedge HCLK);
                chk("htrans_addr", 32'(b.HTRANS), 32'd2);
                chk("hsel_addr", 32'(b.HSEL_MEM), 32'd1);
                chk("haddr", 32'(b.HADDR), 32'(addr));
                chk("hwrite", 32'(b.HWRITE), 32'(we));
                chk("hsize", 32'(b.HSIZE), 32'(size));
                chk("resp_read", 32'(b.resp_read), 32'(!we));
                chk("req_ready_busy", 32'(b.req_ready), 32'd0);
                @(posedge HCLK); #1;
                lat++;
            end
            for (int k = 0; k <= dw; k++) begin
                b.HREADY = (k == dw) && !berr;
                b.HRESP  = (k == dw) && berr;
                b.HRDATA = (k == dw) ? hrdata : $urandom;
                @(negedge HCLK);
                chk("htrans_data", 32'(b.HTRANS), 32'd0);
                chk("hsel_data", 32'(b.HSEL_MEM), 32'd0);
                chk("rsp_valid_data", 32'(b.rsp_valid), 32'd0);
                if (we) chk("hwdata", b.HWDATA, exp_wd);
                @(posedge HCLK); #1;
                lat++;
            end
            // second cycle of a two-cycle error response
            b.HREADY = 1'b1;
            b.HRESP  = berr;
        end

        guard = 0;
        @(negedge HCLK);
        while (!b.rsp_valid && guard < 20) begin
            @(posedge HCLK); #1;
            lat++;
            guard++;
            @(negedge HCLK);
        end
        chk("latency", 32'(lat), 32'(exp_lat));

        for (int k = 0; k <= rdly; k++) begin
            if (k > 0) @(negedge HCLK);
            b.rsp_ready = (k == rdly);
            chk("rsp_valid", 32'(b.rsp_valid), 32'd1);
            chk("rsp_err", 32'(b.rsp_err), 32'(exp_err));
            chk("rsp_rdata", b.rsp_rdata, exp_rd);
            chk("htrans_resp", 32'(b.HTRANS), 32'd0);
            chk("req_ready_resp", 32'(b.req_ready), 32'd0);
            @(posedge HCLK); #1;
            b.HRESP  = 1'b0;
            b.HREADY = 1'b1;
        end
        b.rsp_ready = 1'b0;
        b.req_valid = 1'b0;
        @(negedge HCLK);
        chk("req_ready_after", 32'(b.req_ready), 32'd1);
        chk("rsp_valid_after", 32'(b.rsp_valid), 32'd0);
        $display("txn %0d addr=%h we=%0d size=%0d uns=%0d aw=%0d dw=%0d berr=%0d lat=%0d rdata=%h err=%0d",
                 n_txn, addr, we, size, uns, aw, dw, berr, lat, exp_rd, exp_err);
        n_txn++;
        @(posedge HCLK); #1;
    endtask

    initial begin
        logic [11:0] addr;
        logic [1:0]  size;
        int          lat;
        int          guard;
        n_checks = 0;
        n_errors = 0;
        n_txn    = 0;

        b.req_valid = 1'b0; b.req_addr = '0; b.req_we = 1'b0; b.req_size = 2'd0;
        b.req_unsigned = 1'b0; b.req_wdata = '0; b.rsp_ready = 1'b0;
        b.HRDATA = '0; b.HREADY = 1'b1; b.HRESP = 1'b0;
        b2.req_valid = 1'b0; b2.req_addr = '0; b2.req_we = 1'b0; b2.req_size = 2'd0;
        b2.req_unsigned = 1'b0; b2.req_wdata = '0; b2.rsp_ready = 1'b0;
        b2.HRDATA = '0; b2.HREADY = 1'b1; b2.HRESP = 1'b0;

        HRESET = 1'b1;
        repeat (2) @(negedge HCLK);
        chk("rst_htrans", 32'(b.HTRANS), 32'd0);
        chk("rst_hsel", 32'(b.HSEL_MEM), 32'd0);
        chk("rst_haddr", 32'(b.HADDR), 32'd0);
        chk("rst_hwdata", b.HWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(b.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(b.req_ready), 32'd1);
        chk("rst_hprot", 32'(b.HPROT), 32'h3);
        chk("rst_hburst", 32'(b.HBURST), 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        run_txn(12'h010, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 0);
        run_txn(12'h013, 1'b0, 2'd0, 1'b0, 32'h0, 32'h80FF0000, 0, 0, 1'b0, 0);
        run_txn(12'h013, 1'b0, 2'd0, 1'b1, 32'h0, 32'h80FF0000, 0, 0, 1'b0, 0);
        run_txn(12'h006, 1'b0, 2'd1, 1'b1, 32'h0, 32'h1234ABCD, 0, 5, 1'b0, 0);
        run_txn(12'h002, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, 0);
        run_txn(12'h100, 1'b0, 2'd2, 1'b0, 32'h0, 32'h5555AAAA, 0, 0, 1'b1, 3);
        run_txn(12'h021, 1'b1, 2'd0, 1'b0, 32'h000000A5, 32'h0, 1, 2, 1'b0, 1);
        run_txn(12'h022, 1'b1, 2'd1, 1'b0, 32'h0000BEEF, 32'h0, 0, 1, 1'b0, 0);
        run_txn(12'h030, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, 1);

        for (int i = 0; i < 60; i++) begin
            size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = 12'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size == 2'd2) addr[1:0] = 2'b00;
            end
            run_txn(addr, 1'($urandom), size, 1'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
        end

        // timeout instance: HREADY stuck low after the address phase
        b2.req_valid = 1'b1; b2.req_addr = 12'h020; b2.req_we = 1'b0; b2.req_size = 2'd2;
        b2.HREADY = 1'b1;
        @(posedge HCLK); #1;
        b2.req_valid = 1'b0;
        lat = 1;
        @(posedge HCLK); #1;
        lat = 2;
        b2.HREADY = 1'b0;
        guard = 0;
        @(negedge HCLK);
        while (!b2.rsp_valid && guard < 20) begin
            @(posedge HCLK); #1;
            lat++;
            guard++;
            @(negedge HCLK);
        end
        chk("timeout_latency", 32'(lat), 32'd6);
        chk("timeout_err", 32'(b2.rsp_err), 32'd1);
        chk("timeout_rdata", b2.rsp_rdata, 32'd0);
        b2.rsp_ready = 1'b1;
        @(posedge HCLK); #1;
        b2.rsp_ready = 1'b0;
        b2.HREADY = 1'b1;
        $display("txn %0d timeout load lat=%0d", n_txn, lat);
        n_txn++;

        // asynchronous reset in the middle of a store data phase
        b.req_valid = 1'b1; b.req_addr = 12'h040; b.req_we = 1'b1; b.req_size = 2'd2;
        b.req_wdata = 32'hCAFEF00D; b.HREADY = 1'b1;
        @(posedge HCLK); #1;
        b.req_valid = 1'b0;
        @(posedge HCLK); #1;
        b.HREADY = 1'b0;
        @(negedge HCLK);
        chk("pre_rst_hwdata", b.HWDATA, 32'hCAFEF00D);
        #2;
        HRESET = 1'b1;
        #1;
        chk("mid_rst_hwdata", b.HWDATA, 32'd0);
        chk("mid_rst_htrans", 32'(b.HTRANS), 32'd0);
        chk("mid_rst_hwrite", 32'(b.HWRITE), 32'd0);
        chk("mid_rst_hsize", 32'(b.HSIZE), 32'd0);
        chk("mid_rst_rsp_valid", 32'(b.rsp_valid), 32'd0);
        chk("mid_rst_rdata", b.rsp_rdata, 32'd0);
        chk("mid_rst_req_ready", 32'(b.req_ready), 32'd1);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        b.HREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            chk("post_rst_no_rsp", 32'(b.rsp_valid), 32'd0);
            chk("post_rst_ready", 32'(b.req_ready), 32'd1);
        end
        $display("txn %0d reset during data phase", n_txn);
        n_txn++;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
